// File: rtl/gat_layer_scheduler.sv
// Layer sequencer for the GAT core: waits for BRAM loads, launches each layer,
// waits for core completion, and reports busy/done/timeout plus a run cycle count.
module gat_layer_scheduler #(
  parameter int NUM_LAYERS     = 2,
  parameter int TIMEOUT_CYCLES = 16777216,
  parameter int CYC_CNT_W      = 32,
  parameter int TMO_W          = 25
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 host_start,
  input  logic                 host_clear,
  input  logic                 h_data_bram_load_done,
  input  logic                 h_node_info_bram_load_done,
  input  logic                 wgt_bram_load_done,
  input  logic                 core_ready,
  output logic                 gat_layer,
  output logic                 core_start,
  output logic                 wgt_reload_req,
  output logic                 busy,
  output logic                 done,
  output logic                 err_timeout,
  output logic                 layer_idx,
  output logic [CYC_CNT_W-1:0] run_cycles
);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_LOAD, S_START, S_RUN, S_NEXT, S_DONE, S_ERR
  } state_t;

  localparam logic [TMO_W-1:0]     TMO_LAST   = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CYC_CNT_W-1:0] CYC_MAX    = '1;
  localparam logic                 LAST_LAYER = 1'(NUM_LAYERS - 1);

  state_t                 r_state;
  logic                   r_gat_layer;
  logic                   r_core_start;
  logic                   r_wgt_reload_req;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_err_timeout;
  logic                   r_layer_idx;
  logic [CYC_CNT_W-1:0]   r_run_cycles;
  logic [TMO_W-1:0]       r_wd;
  logic                   r_wgt_arm;
  logic                   r_rdy_arm;

  logic w_h_loaded;
  logic w_loads_ok;
  logic w_active;

  assign w_h_loaded = h_data_bram_load_done & h_node_info_bram_load_done;
  // Later layers need a fresh low->high on the weight flag, not the stale high
  // left over from the previous layer's load.
  assign w_loads_ok = w_h_loaded & wgt_bram_load_done &
                      ((r_layer_idx == 1'b0) | r_wgt_arm);
  assign w_active   = (r_state == S_WAIT_LOAD) | (r_state == S_START) |
                      (r_state == S_RUN)       | (r_state == S_NEXT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state          <= S_IDLE;
      r_gat_layer      <= 1'b0;
      r_core_start     <= 1'b0;
      r_wgt_reload_req <= 1'b0;
      r_busy           <= 1'b0;
      r_done           <= 1'b0;
      r_err_timeout    <= 1'b0;
      r_layer_idx      <= 1'b0;
      r_run_cycles     <= '0;
      r_wd             <= '0;
      r_wgt_arm        <= 1'b0;
      r_rdy_arm        <= 1'b0;
    end else if (host_clear) begin
      r_state          <= S_IDLE;
      r_gat_layer      <= 1'b0;
      r_core_start     <= 1'b0;
      r_wgt_reload_req <= 1'b0;
      r_busy           <= 1'b0;
      r_done           <= 1'b0;
      r_err_timeout    <= 1'b0;
      r_layer_idx      <= 1'b0;
      r_run_cycles     <= '0;
      r_wd             <= '0;
      r_wgt_arm        <= 1'b0;
      r_rdy_arm        <= 1'b0;
    end else begin
      r_core_start <= 1'b0;
      if (w_active && (r_run_cycles != CYC_MAX))
        r_run_cycles <= r_run_cycles + 1'b1;

      case (r_state)
        S_IDLE, S_DONE, S_ERR: begin
          if (host_start) begin
            r_state          <= S_WAIT_LOAD;
            r_layer_idx      <= 1'b0;
            r_gat_layer      <= 1'b0;
            r_run_cycles     <= '0;
            r_done           <= 1'b0;
            r_err_timeout    <= 1'b0;
            r_busy           <= 1'b1;
            r_wgt_arm        <= 1'b0;
            r_wgt_reload_req <= 1'b0;
          end
        end
        S_WAIT_LOAD: begin
          if ((r_layer_idx != 1'b0) && !wgt_bram_load_done)
            r_wgt_arm <= 1'b1;
          if (w_loads_ok) begin
            r_state          <= S_START;
            r_core_start     <= 1'b1;
            r_wgt_reload_req <= 1'b0;
          end
        end
        S_START: begin
          r_wd      <= '0;
          r_rdy_arm <= 1'b0;
          r_state   <= S_RUN;
        end
        S_RUN: begin
          // Completion is checked first so it beats a coincident timeout.
          if (r_rdy_arm && core_ready) begin
            r_state <= S_NEXT;
          end else if (r_wd == TMO_LAST) begin
            r_state       <= S_ERR;
            r_err_timeout <= 1'b1;
            r_busy        <= 1'b0;
          end else begin
            r_wd <= r_wd + 1'b1;
            if (!core_ready) r_rdy_arm <= 1'b1;
          end
        end
        S_NEXT: begin
          if (r_layer_idx == LAST_LAYER) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
          end else begin
            r_state          <= S_WAIT_LOAD;
            r_layer_idx      <= r_layer_idx + 1'b1;
            r_gat_layer      <= r_layer_idx + 1'b1;
            r_wgt_arm        <= 1'b0;
            r_wgt_reload_req <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign gat_layer      = r_gat_layer;
  assign core_start     = r_core_start;
  assign wgt_reload_req = r_wgt_reload_req;
  assign busy           = r_busy;
  assign done           = r_done;
  assign err_timeout    = r_err_timeout;
  assign layer_idx      = r_layer_idx;
  assign run_cycles     = r_run_cycles;

endmodule

// File: tb/tb_gat_layer_scheduler.sv
// Bench for gat_layer_scheduler: randomized load/ready timing, expected event
// times derived arithmetically from the scheduling rules.
module tb_gat_layer_scheduler;

  logic clk = 1'b0;
  logic rst_n;
  logic host_start, host_clear, hd_done, hn_done, wgt_done, core_ready;

  logic       gl0, cs0, wr0, busy0, done0, err0, li0;
  logic [7:0] rc0;
  logic       gl1, cs1, wr1, busy1, done1, err1, li1;
  logic [3:0] rc1;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  gat_layer_scheduler #(.NUM_LAYERS(2), .TIMEOUT_CYCLES(16), .CYC_CNT_W(8), .TMO_W(5)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .host_start(host_start), .host_clear(host_clear),
    .h_data_bram_load_done(hd_done), .h_node_info_bram_load_done(hn_done),
    .wgt_bram_load_done(wgt_done), .core_ready(core_ready),
    .gat_layer(gl0), .core_start(cs0), .wgt_reload_req(wr0), .busy(busy0),
    .done(done0), .err_timeout(err0), .layer_idx(li0), .run_cycles(rc0)
  );

  gat_layer_scheduler #(.NUM_LAYERS(1), .TIMEOUT_CYCLES(64), .CYC_CNT_W(4), .TMO_W(7)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .host_start(host_start), .host_clear(host_clear),
    .h_data_bram_load_done(hd_done), .h_node_info_bram_load_done(hn_done),
    .wgt_bram_load_done(wgt_done), .core_ready(core_ready),
    .gat_layer(gl1), .core_start(cs1), .wgt_reload_req(wr1), .busy(busy1),
    .done(done1), .err_timeout(err1), .layer_idx(li1), .run_cycles(rc1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_dut();
    host_start = 1'b0;
    host_clear = 1'b1;
    @(posedge clk); #1;
    host_clear = 1'b0;
  endtask

  // One two-layer inference. Milestones are cycle numbers relative to the
  // host_start cycle (k=0); the DUT state for cycle k is observed at its negedge.
  task automatic run_scn(input int sid, input int hA, input int w0, input int a, input int b,
                         input int e, input int f, input int a2, input int b2, input bit stuck);
    int c0, s0, dd0, rr0, q, s1, dd1, rr1, dn, last, hs, exp_rc;
    string t;
    c0 = 1;
    if (hA > c0) c0 = hA;
    if (w0 > c0) c0 = w0;
    s0  = c0 + 1;
    dd0 = s0 + 1 + a;
    rr0 = dd0 + b;
    q   = rr0 + 2;
    if (stuck) begin
      s1 = 1 << 20; dd1 = s1; rr1 = s1; dn = 1 << 21; last = q + 20;
    end else begin
      s1 = q + e + f + 1; dd1 = s1 + 1 + a2; rr1 = dd1 + b2; dn = rr1 + 2; last = dn + 3;
    end
    hs = $urandom_range(q, 1);
    for (int k = 0; k <= last; k++) begin
      host_start = (k == 0) || (k == hs);
      hd_done    = (k >= hA);
      hn_done    = (k >= hA);
      wgt_done   = (k >= w0) && (stuck || !(k >= q + e && k < q + e + f));
      core_ready = !((k >= dd0 && k < rr0) || (k >= dd1 && k < rr1));
      @(negedge clk);
      if (k >= 1) begin
        t = $sformatf("scn%0d k%0d", sid, k);
        exp_rc = (k < dn) ? k - 1 : dn - 1;
        chk({t, " busy"},       32'(busy0), 32'(k < dn));
        chk({t, " core_start"}, 32'(cs0),   32'((k == s0) || (k == s1)));
        chk({t, " gat_layer"},  32'(gl0),   32'(k >= q));
        chk({t, " layer_idx"},  32'(li0),   32'(k >= q));
        chk({t, " wgt_req"},    32'(wr0),   32'(k >= q && k < s1));
        chk({t, " done"},       32'(done0), 32'(k >= dn));
        chk({t, " err"},        32'(err0),  32'(0));
        chk({t, " run_cycles"}, 32'(rc0),   32'(exp_rc));
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    string t;
    rst_n = 1'b0;
    host_start = 1'b0; host_clear = 1'b0;
    hd_done = 1'b0; hn_done = 1'b0; wgt_done = 1'b0; core_ready = 1'b1;

    repeat (2) @(negedge clk);
    chk("rst busy", 32'(busy0), 32'(0));
    chk("rst core_start", 32'(cs0), 32'(0));
    chk("rst gat_layer", 32'(gl0), 32'(0));
    chk("rst wgt_req", 32'(wr0), 32'(0));
    chk("rst done", 32'(done0), 32'(0));
    chk("rst err", 32'(err0), 32'(0));
    chk("rst layer_idx", 32'(li0), 32'(0));
    chk("rst run_cycles", 32'(rc0), 32'(0));
    chk("rst busy1", 32'(busy1), 32'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Chained random inferences: each after the first starts from DONE.
    for (int s = 0; s < 6; s++)
      run_scn(s, $urandom_range(4, 0), $urandom_range(4, 0), $urandom_range(3, 0),
              $urandom_range(4, 1), $urandom_range(3, 0), $urandom_range(3, 1),
              $urandom_range(3, 0), $urandom_range(4, 1), 1'b0);
    // Completion lands on the last watchdog cycle of layer 0.
    run_scn(10, 0, 0, 2, 13, 1, 1, 0, 2, 1'b0);
    // Weight flag never drops for layer 1.
    run_scn(11, 0, 0, 1, 2, 0, 1, 0, 1, 1'b1);
    clear_dut();

    // Watchdog: core never leaves ready.
    for (int k = 0; k <= 24; k++) begin
      host_start = (k == 0);
      hd_done = 1'b1; hn_done = 1'b1; wgt_done = 1'b1; core_ready = 1'b1;
      @(negedge clk);
      if (k >= 1) begin
        t = $sformatf("tmo k%0d", k);
        chk({t, " err"},        32'(err0),  32'(k >= 19));
        chk({t, " busy"},       32'(busy0), 32'(k < 19));
        chk({t, " core_start"}, 32'(cs0),   32'(k == 2));
        chk({t, " done"},       32'(done0), 32'(0));
        chk({t, " run_cycles"}, 32'(rc0),   32'((k < 19) ? k - 1 : 18));
      end
      @(posedge clk); #1;
    end

    // host_clear mid-RUN, then restart (first start comes from ERR).
    for (int k = 0; k <= 15; k++) begin
      host_start = (k == 0) || (k == 12);
      host_clear = (k == 10);
      core_ready = !(k >= 5 && k < 20);
      @(negedge clk);
      t = $sformatf("clr k%0d", k);
      if (k == 1)  chk({t, " err"}, 32'(err0), 32'(0));
      if (k == 10) begin
        chk({t, " busy"}, 32'(busy0), 32'(1));
        chk({t, " run_cycles"}, 32'(rc0), 32'(9));
      end
      if (k == 11) begin
        chk({t, " busy"},       32'(busy0), 32'(0));
        chk({t, " core_start"}, 32'(cs0),   32'(0));
        chk({t, " done"},       32'(done0), 32'(0));
        chk({t, " run_cycles"}, 32'(rc0),   32'(0));
        chk({t, " layer_idx"},  32'(li0),   32'(0));
      end
      if (k == 13) chk({t, " busy"}, 32'(busy0), 32'(1));
      if (k == 14) begin
        chk({t, " core_start"}, 32'(cs0), 32'(1));
        chk({t, " gat_layer"},  32'(gl0), 32'(0));
        chk({t, " run_cycles"}, 32'(rc0), 32'(1));
      end
      @(posedge clk); #1;
    end
    host_clear = 1'b0;
    clear_dut();

    // Single-layer instance with 4-bit saturating counter; long RUN.
    for (int k = 0; k <= 36; k++) begin
      host_start = (k == 0);
      hd_done = 1'b1; hn_done = 1'b1; wgt_done = 1'b1;
      core_ready = !(k >= 5 && k < 30);
      @(negedge clk);
      if (k >= 1) begin
        t = $sformatf("one k%0d", k);
        chk({t, " core_start"}, 32'(cs1),   32'(k == 2));
        chk({t, " wgt_req"},    32'(wr1),   32'(0));
        chk({t, " gat_layer"},  32'(gl1),   32'(0));
        chk({t, " busy"},       32'(busy1), 32'(k < 32));
        chk({t, " done"},       32'(done1), 32'(k >= 32));
        chk({t, " run_cycles"}, 32'(rc1),   32'((k - 1 > 15) ? 15 : k - 1));
        chk({t, " err0"},       32'(err0),  32'(k >= 19));
      end
      @(posedge clk); #1;
    end
    clear_dut();

    // Asynchronous reset in the middle of RUN.
    for (int k = 0; k <= 5; k++) begin
      host_start = (k == 0);
      core_ready = 1'b1;
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("arst pre busy", 32'(busy0), 32'(1));
    rst_n = 1'b0;
    #1;
    chk("arst busy", 32'(busy0), 32'(0));
    chk("arst run_cycles", 32'(rc0), 32'(0));
    chk("arst core_start", 32'(cs0), 32'(0));
    chk("arst busy1", 32'(busy1), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("arst idle busy", 32'(busy0), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
